keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans the 4x3 matrix keypad: drives one row high at a time on keypadr, samples keypadc,
//  debounces over whole scan frames and emits a 4-bit key code with a one-cycle press strobe.
//  Replaces the "any column high" load detect at top level; feeds clock/display control logic.
// PARAMETERS
//  SCAN_DIV         16'd4000  clk cycles per row slot (1 ms at 4 MHz; frame = 4 slots)
//  DEBOUNCE_FRAMES  8'd5      consecutive identical frames needed to accept a press or release
//  REPEAT_DELAY     8'd125    frames held before first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_RATE      8'd25     frames between subsequent auto-repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  clk        in   1  system clock (4 MHz)
//  rst_n      in   1  synchronous reset, active-low
//  keypadc    in   3  column inputs, active-high (pulled low), asynchronous
//  keypadr    out  4  row drive, one-hot active-high
//  key_code   out  4  code of accepted key; 4'hF when none
//  key_valid  out  1  one-cycle strobe: new press accepted (or repeat)
//  key_held   out  1  level: debounced key currently held
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): keypadr=4'b0001, key_code=4'hF, key_valid=0, key_held=0,
//    divider, row index, debounce counters = 0, FSM = IDLE. Reset mid-press: press discarded.
//  - keypadc passes a 2-flop synchronizer before use.
//  - Divider counts 0..SCAN_DIV-1; at SCAN_DIV-1 synced columns for the active row are sampled,
//    next cycle the row advances (0->1->2->3->0, keypadr rotates left, wraps to 4'b0001).
//  - Key map (row,col0..2): r0 1,2,3; r1 4,5,6; r2 7,8,9; r3 *=4'hA,0=4'h0,#=4'hB.
//  - Frame result at row-3 sample: exactly one key in frame -> its code; zero or >1 -> NONE (4'hF).
//  - Debounce FSM, evaluated once per frame end (cnt saturates, 8-bit):
//    IDLE:    frame!=NONE -> CAND, cand=frame, cnt=1.
//    CAND:    frame==cand -> cnt++; cnt reaches DEBOUNCE_FRAMES -> PRESSED, key_code=cand,
//             key_valid=1 one cycle, key_held=1. frame==NONE -> IDLE. other key -> cand=frame, cnt=1.
//    PRESSED: frame!=cand -> RELEASE, cnt=1.
//    RELEASE: frame==cand -> PRESSED; else cnt++; reaches DEBOUNCE_FRAMES -> IDLE,
//             key_held=0, key_code=4'hF. Direct key change must pass through release first.
//  - DEBOUNCE_FRAMES=1: accept on first frame. Latency: key_valid rises the cycle after the
//    DEBOUNCE_FRAMES-th matching frame's row-3 sample.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in PRESSED, repeat counter counts frames; at REPEAT_DELAY then
//  every REPEAT_RATE frames, key_valid pulses again with same key_code; counter clears on
//  leaving PRESSED (RELEASE->PRESSED restarts delay). Undefined: exactly one key_valid per press,
//  repeat logic and REPEAT_* parameters unused.
// STRUCTURE
//  keypad_pkg: KEY_NONE=4'hF, KEY_STAR=4'hA, KEY_HASH=4'hB, FSM state encoding
//  (IDLE/CAND/PRESSED/RELEASE), row-to-code lookup function.
//  Sub-module keypad_debounce: frame-result input + frame strobe -> FSM, key_code/valid/held,
//  repeat logic. Top keeps divider, row rotation, synchronizer, frame decode.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_DELAY=4, REPEAT_RATE=2; frame=16 clk)
//  1 rst_n low 2 cycles -> keypadr=0001, key_code=F, key_valid=0, key_held=0; rows then cycle
//    0001,0010,0100,1000 each 4 clk.
//  2 key '5' (keypadc=3'b010 while keypadr=0010) held 3 frames -> one key_valid, key_code=5,
//    key_held=1; release 3 frames -> key_held=0, key_code=F.
//  3 '#' bounce: present 2 frames, absent 1, present 3 -> exactly one key_valid, code=B.
//  4 '1'+'2' together -> no key_valid; release '2' -> after 3 frames key_valid, code=1.
//  5 reset asserted mid-CAND after 2 frames of '7' -> outputs at reset values, no strobe.
//  6 KEYPAD_REPEAT_EN: hold '0' 12 frames -> key_valid at accept, +4, +6, +8 frames, code=0;
//    without macro -> single key_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x3 matrix keypad scanner:
//   KEY_NONE / KEY_STAR / KEY_HASH / KEY_ZERO : special key codes
//   db_state_t                                : debounce FSM states
//   key_lookup(row, col)                      : matrix position -> 4-bit key code
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_ZERO = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAND    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_RELEASE = 2'd3
    } db_state_t;

    // Rows 0..2 carry the digits 1..9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = KEY_ZERO;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
// Frame-level debounce for the keypad scanner. Consumes one frame result per
// scan frame and decides when a key is accepted, held and released.
// Optional macro: KEYPAD_REPEAT_EN enables auto-repeat of key_valid while held.
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous reset, active-low
//   frame_strobe  in   one-cycle pulse when frame_code is valid (end of row 3)
//   frame_code    in   key seen in the frame, KEY_NONE for none or several
//   key_code      out  accepted key, KEY_NONE when no key is held
//   key_valid     out  one-cycle strobe on acceptance (and on repeats)
//   key_held      out  debounced key currently held
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter logic [7:0] DEBOUNCE_FRAMES = 8'd5,
    parameter logic [7:0] REPEAT_DELAY    = 8'd125,
    parameter logic [7:0] REPEAT_RATE     = 8'd25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_strobe,
    input  logic [3:0] frame_code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    db_state_t  state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic [3:0] code_d;
    logic       valid_d;
    logic       held_d;

`ifdef KEYPAD_REPEAT_EN
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       rep_phase_q, rep_phase_d;
`else
    logic [15:0] unused_repeat_cfg;
    assign unused_repeat_cfg = {REPEAT_DELAY, REPEAT_RATE};
`endif

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cand_q    <= KEY_NONE;
            cnt_q     <= 8'd0;
            key_code  <= KEY_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_q   <= 8'd0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    // The FSM only moves on frame_strobe. Comparisons use >= so that a
    // threshold of 0 or 1 both mean "accept on the first frame".
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = key_code;
        valid_d = 1'b0;
        held_d  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
`endif

        if (frame_strobe) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_code != KEY_NONE) begin
                        cand_d = frame_code;
                        cnt_d  = 8'd1;
                        if (8'd1 >= DEBOUNCE_FRAMES) begin
                            state_d = ST_PRESSED;
                            cnt_d   = 8'd0;
                            code_d  = frame_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end else begin
                            state_d = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEBOUNCE_FRAMES) begin
                            state_d = ST_PRESSED;
                            cnt_d   = 8'd0;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end
                    end else if (frame_code == KEY_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = 8'd1;
                    end
                end
                ST_PRESSED: begin
                    // Any other frame, including a different key, starts a release;
                    // a new key is only taken after the old one is fully released.
                    if (frame_code != cand_q) begin
                        cnt_d = 8'd1;
                        if (8'd1 >= DEBOUNCE_FRAMES) begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                            code_d  = KEY_NONE;
                            held_d  = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (frame_code == cand_q) begin
                        state_d = ST_PRESSED;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEBOUNCE_FRAMES) begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                            code_d  = KEY_NONE;
                            held_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

`ifdef KEYPAD_REPEAT_EN
            // Phase 0 waits REPEAT_DELAY held frames, phase 1 then fires every
            // REPEAT_RATE frames. Any frame outside a steady PRESSED restarts it.
            if (state_q == ST_PRESSED && frame_code == cand_q) begin
                rep_cnt_d = (rep_cnt_q == 8'hFF) ? rep_cnt_q : rep_cnt_q + 8'd1;
                if (rep_cnt_d >= (rep_phase_q ? REPEAT_RATE : REPEAT_DELAY)) begin
                    valid_d     = 1'b1;
                    rep_cnt_d   = 8'd0;
                    rep_phase_d = 1'b1;
                end
            end else begin
                rep_cnt_d   = 8'd0;
                rep_phase_d = 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x3 matrix keypad one row at a time, decodes each scan frame into a
// single key code and hands it to keypad_debounce.
// Optional macro: KEYPAD_REPEAT_EN (auto-repeat, handled in keypad_debounce).
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   keypadc    in   column inputs, active-high, asynchronous
//   keypadr    out  one-hot active-high row drive
//   key_code   out  accepted key code, 4'hF when none
//   key_valid  out  one-cycle press (or repeat) strobe
//   key_held   out  debounced key currently held
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV        = 16'd4000,
    parameter logic [7:0]  DEBOUNCE_FRAMES = 8'd5,
    parameter logic [7:0]  REPEAT_DELAY    = 8'd125,
    parameter logic [7:0]  REPEAT_RATE     = 8'd25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] keypadc,
    output logic [3:0] keypadr,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    logic [2:0]  col_meta;
    logic [2:0]  col_sync;
    logic [15:0] div_cnt;
    logic [1:0]  row_idx;
    logic [1:0]  acc_hits;
    logic [3:0]  acc_code;
    logic        slot_end;
    logic        frame_strobe;
    logic [1:0]  row_hits;
    logic [3:0]  row_code;
    logic [2:0]  hit_sum;
    logic [3:0]  frame_code;

    assign slot_end     = (div_cnt == SCAN_DIV - 16'd1);
    assign frame_strobe = slot_end && (row_idx == 2'd3);
    assign keypadr      = 4'b0001 << row_idx;

    // Combines the keys already seen this frame with the row being sampled.
    // acc_hits saturates at 2: beyond one key the exact count does not matter.
    always_comb begin
        row_hits   = 2'd0;
        row_code   = KEY_NONE;
        for (int c = 0; c < 3; c++) begin
            if (col_sync[c]) begin
                if (row_hits != 2'd2) begin
                    row_hits = row_hits + 2'd1;
                end
                row_code = key_lookup(row_idx, 2'(c));
            end
        end
        hit_sum    = {1'b0, acc_hits} + {1'b0, row_hits};
        frame_code = KEY_NONE;
        if (hit_sum == 3'd1) begin
            frame_code = (acc_hits == 2'd1) ? acc_code : row_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta <= 3'b000;
            col_sync <= 3'b000;
            div_cnt  <= 16'd0;
            row_idx  <= 2'd0;
            acc_hits <= 2'd0;
            acc_code <= KEY_NONE;
        end else begin
            col_meta <= keypadc;
            col_sync <= col_meta;
            if (slot_end) begin
                div_cnt <= 16'd0;
                row_idx <= row_idx + 2'd1;
                if (row_idx == 2'd3) begin
                    acc_hits <= 2'd0;
                    acc_code <= KEY_NONE;
                end else begin
                    acc_hits <= (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
                    acc_code <= frame_code;
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_strobe (frame_strobe),
        .frame_code   (frame_code),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_held     (key_held)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with a 16-cycle scan frame.
// A frame-level model predicts outputs every cycle; directed scenarios add
// hand-computed expectations (strobe counts, codes, strobe times).
// Honours KEYPAD_REPEAT_EN the same way as the design.
module tb_keypad_scanner;

    localparam logic [15:0] TB_SCAN_DIV = 16'd4;
    localparam logic [7:0]  TB_DF       = 8'd3;
    localparam logic [7:0]  TB_RD       = 8'd4;
    localparam logic [7:0]  TB_RR       = 8'd2;
    localparam int          FRAME       = 4 * int'(TB_SCAN_DIV);

    localparam logic [11:0] M_NONE = 12'b0;
    localparam logic [11:0] M_1    = 12'b0000_0000_0001;
    localparam logic [11:0] M_2    = 12'b0000_0000_0010;
    localparam logic [11:0] M_5    = 12'b0000_0001_0000;
    localparam logic [11:0] M_7    = 12'b0000_0100_0000;
    localparam logic [11:0] M_0    = 12'b0100_0000_0000;
    localparam logic [11:0] M_HASH = 12'b1000_0000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] keypadc;
    logic [3:0] keypadr;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [11:0] key_mask = 12'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int last_k   = -1;
    logic [3:0] last_code = 4'hF;
    int base;

    // model state
    bit         model_ok = 1'b0;
    int         k = 0;
    logic       m_held;
    logic [3:0] m_code;
    logic       m_valid;
    logic [3:0] run_key;
    int         run_len;
    int         miss_len;
    int         hold_len;

    keypad_scanner #(
        .SCAN_DIV        (TB_SCAN_DIV),
        .DEBOUNCE_FRAMES (TB_DF),
        .REPEAT_DELAY    (TB_RD),
        .REPEAT_RATE     (TB_RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keypadc   (keypadc),
        .keypadr   (keypadr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its row drive to its column.
    always_comb begin
        keypadc = 3'b000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keypadr[r] === 1'b1 && key_mask[r * 3 + c]) begin
                    keypadc[c] = 1'b1;
                end
            end
        end
    end

    function automatic logic [3:0] expected_frame_code(input logic [11:0] mask);
        int n;
        int idx;
        n   = 0;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (mask[i]) begin
                n++;
                idx = i;
            end
        end
        if (n != 1) return 4'hF;
        if (idx == 9)  return 4'hA;
        if (idx == 10) return 4'h0;
        if (idx == 11) return 4'hB;
        return 4'(idx + 1);
    endfunction

    // Run-length view of debouncing: accept after DF identical key frames,
    // release after DF consecutive frames that are not the held key.
    task automatic model_frame(input logic [3:0] f);
        if (!m_held) begin
            if (f == 4'hF) begin
                run_len = 0;
            end else if (run_len > 0 && f == run_key) begin
                run_len++;
            end else begin
                run_key = f;
                run_len = 1;
            end
            if (run_len >= int'(TB_DF)) begin
                m_held   = 1'b1;
                m_code   = run_key;
                m_valid  = 1'b1;
                hold_len = 0;
                miss_len = 0;
            end
        end else if (f == m_code) begin
            hold_len = (miss_len > 0) ? 0 : hold_len + 1;
            miss_len = 0;
`ifdef KEYPAD_REPEAT_EN
            if (hold_len == int'(TB_RD) ||
                (hold_len > int'(TB_RD) && (hold_len - int'(TB_RD)) % int'(TB_RR) == 0)) begin
                m_valid = 1'b1;
            end
`endif
        end else begin
            miss_len++;
            hold_len = 0;
            if (miss_len >= int'(TB_DF)) begin
                m_held  = 1'b0;
                m_code  = 4'hF;
                run_len = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            k        = 0;
            m_held   = 1'b0;
            m_code   = 4'hF;
            m_valid  = 1'b0;
            run_key  = 4'hF;
            run_len  = 0;
            miss_len = 0;
            hold_len = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            k++;
            m_valid = 1'b0;
            if (k % FRAME == 0) begin
                model_frame(expected_frame_code(key_mask));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compare_loop();
        logic [3:0] exp_r;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                exp_r = 4'b0001 << ((k / 4) % 4);
                checkOutput("keypadr", 16'(keypadr), 16'(exp_r));
                checkOutput("key_code", 16'(key_code), 16'(m_code));
                checkOutput("key_valid", 16'(key_valid), 16'(m_valid));
                checkOutput("key_held", 16'(key_held), 16'(m_held));
            end
            if (key_valid === 1'b1) begin
                pulses++;
                last_code = key_code;
                last_k    = k;
            end
        end
    endtask

    // Holds a key pattern for whole frames; starts and ends just after a frame end.
    task automatic applyStimulus(input logic [11:0] mask, input int frames);
        key_mask = mask;
        repeat (frames * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        key_mask = M_NONE;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset keypadr", 16'(keypadr), 16'h1);
        checkOutput("reset key_code", 16'(key_code), 16'hF);
        checkOutput("reset key_valid", 16'(key_valid), 16'h0);
        checkOutput("reset key_held", 16'(key_held), 16'h0);
        rst_n = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        // 1: reset values and row rotation (rotation is checked every cycle)
        apply_reset();

        // 2: '5' accepted on the third frame, released after three frames
        base = pulses;
        applyStimulus(M_5, 2);
        checkOutput("t2 held before 3rd frame", 16'(key_held), 16'h0);
        applyStimulus(M_5, 1);
        checkOutput("t2 held", 16'(key_held), 16'h1);
        checkOutput("t2 code", 16'(key_code), 16'h5);
        checkOutput("t2 valid", 16'(key_valid), 16'h1);
        applyStimulus(M_NONE, 2);
        checkOutput("t2 held during release", 16'(key_held), 16'h1);
        applyStimulus(M_NONE, 1);
        checkOutput("t2 released held", 16'(key_held), 16'h0);
        checkOutput("t2 released code", 16'(key_code), 16'hF);
        checkOutput("t2 pulses", 16'(pulses - base), 16'd1);
        checkOutput("t2 strobe time", 16'(last_k), 16'd64);

        // 3: '#' bouncing 2 on / 1 off / 3 on
        apply_reset();
        base = pulses;
        applyStimulus(M_HASH, 2);
        applyStimulus(M_NONE, 1);
        applyStimulus(M_HASH, 3);
        checkOutput("t3 code", 16'(key_code), 16'hB);
        applyStimulus(M_NONE, 3);
        checkOutput("t3 pulses", 16'(pulses - base), 16'd1);
        checkOutput("t3 last code", 16'(last_code), 16'hB);
        checkOutput("t3 strobe time", 16'(last_k), 16'd112);

        // 4: '1'+'2' together are ignored; '1' alone then accepted
        apply_reset();
        base = pulses;
        applyStimulus(M_1 | M_2, 2);
        checkOutput("t4 no pulse on two keys", 16'(pulses - base), 16'd0);
        applyStimulus(M_1, 3);
        checkOutput("t4 code", 16'(key_code), 16'h1);
        applyStimulus(M_NONE, 3);
        checkOutput("t4 pulses", 16'(pulses - base), 16'd1);
        checkOutput("t4 strobe time", 16'(last_k), 16'd96);

        // 5: reset in the middle of a candidate '7' discards it
        apply_reset();
        base = pulses;
        applyStimulus(M_7, 2);
        checkOutput("t5 held before reset", 16'(key_held), 16'h0);
        apply_reset();
        applyStimulus(M_7, 2);
        applyStimulus(M_NONE, 1);
        checkOutput("t5 pulses", 16'(pulses - base), 16'd0);
        checkOutput("t5 code", 16'(key_code), 16'hF);

        // 6: '0' held 12 frames
        apply_reset();
        base = pulses;
        applyStimulus(M_0, 12);
        checkOutput("t6 code", 16'(key_code), 16'h0);
        applyStimulus(M_NONE, 3);
        checkOutput("t6 last code", 16'(last_code), 16'h0);
`ifdef KEYPAD_REPEAT_EN
        checkOutput("t6 pulses", 16'(pulses - base), 16'd4);
        checkOutput("t6 last strobe time", 16'(last_k), 16'd192);
`else
        checkOutput("t6 pulses", 16'(pulses - base), 16'd1);
        checkOutput("t6 last strobe time", 16'(last_k), 16'd64);
`endif

        // 7: a short gap while held does not release or re-strobe
        apply_reset();
        base = pulses;
        applyStimulus(M_5, 3);
        applyStimulus(M_NONE, 2);
        checkOutput("t7 held through gap", 16'(key_held), 16'h1);
        applyStimulus(M_5, 3);
        applyStimulus(M_NONE, 3);
        checkOutput("t7 pulses", 16'(pulses - base), 16'd1);
        checkOutput("t7 released held", 16'(key_held), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
